// File: rtl/rtc_bus_scheduler.sv
// rtc_bus_scheduler
// Sequences every transaction to the external RTC over the multiplexed 8-bit
// address/data bus. Each register takes one FRAME_LEN-cycle frame: an address
// phase (ad_n low, address latched with cs_n/wr_n) followed by a data phase
// (cs_n with rd_n for reads, or with wr_n for writes).
// Three requesters are arbitrated with priority init > write > read.
//
// Ports:
//   reloj, resetM           clock, synchronous active-high reset
//   req_ini/req_wr/req_rd   one-cycle request pulses (latched while busy)
//   wr_grp                  register group for req_wr (11 = dropped)
//   wr_data                 write byte for register wr_idx
//   bus_in                  byte read back from the RTC
//   cs_n/rd_n/wr_n/ad_n     RTC strobes, active low
//   bus_oe/bus_out          bus drive enable and driven address/data
//   wr_idx                  register whose write data is wanted (F = none)
//   rd_idx/rd_data/rd_valid captured read byte and its index
//   busy/done/cur_op        transaction status
module rtc_bus_scheduler #(
    parameter int FRAME_LEN = 32
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       req_ini,
    input  logic       req_wr,
    input  logic [1:0] wr_grp,
    input  logic       req_rd,
    input  logic [7:0] wr_data,
    input  logic [7:0] bus_in,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n,
    output logic       bus_oe,
    output logic [7:0] bus_out,
    output logic [3:0] wr_idx,
    output logic [3:0] rd_idx,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic [1:0] cur_op
);

    localparam int FCW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;
    typedef enum logic [1:0] {OP_NONE = 2'b00, OP_READ = 2'b01,
                              OP_WRITE = 2'b10, OP_INIT = 2'b11} op_t;

    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic [FCW-1:0] fc_q, fc_d;
    logic [3:0]     frm_q, frm_d;
    logic [3:0]     base_q, base_d;
    logic [1:0]     grp_q, grp_d;
    logic           pendIni_q, pendIni_d, pendWr_q, pendWr_d, pendRd_q, pendRd_d;
    logic           csN_q, csN_d, rdN_q, rdN_d, wrN_q, wrN_d, adN_q, adN_d;
    logic           busOe_q, busOe_d, rdValid_q, rdValid_d;
    logic           busy_q, busy_d, done_q, done_d;
    logic [7:0]     busOut_q, busOut_d, rdData_q, rdData_d;
    logic [3:0]     wrIdx_q, wrIdx_d, rdIdx_q, rdIdx_d;
    logic [3:0]     idx_d;
    logic           inXfer, isRead, isWriteLike;

    function automatic logic [7:0] regAddr(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h24;
            4'd1:    return 8'h25;
            4'd2:    return 8'h26;
            4'd3:    return 8'h21;
            4'd4:    return 8'h22;
            4'd5:    return 8'h23;
            4'd6:    return 8'h41;
            4'd7:    return 8'h42;
            4'd8:    return 8'h43;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] initAddr(input logic [3:0] frm);
        return (frm == 4'd2) ? 8'h10 : 8'h02;
    endfunction

    function automatic logic [7:0] initData(input logic [3:0] frm);
        case (frm)
            4'd0:    return 8'h10;
            4'd2:    return 8'hD2;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic inWin(input logic [FCW-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

    // Next-state logic. Output registers are computed from the next-state
    // values so that each strobe lines up with the fc value of its own cycle.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        fc_d      = fc_q;
        frm_d     = frm_q;
        base_d    = base_q;
        grp_d     = grp_q;
        pendIni_d = pendIni_q;
        pendWr_d  = pendWr_q;
        pendRd_d  = pendRd_q;

        case (state_q)
            S_IDLE: begin
                if (pendIni_q || pendWr_q || pendRd_q) begin
                    state_d = S_XFER;
                    fc_d    = '0;
                    frm_d   = 4'd0;
                    if (pendIni_q) begin
                        op_d      = OP_INIT;
                        base_d    = 4'd0;
                        pendIni_d = 1'b0;
                    end else if (pendWr_q) begin
                        op_d     = OP_WRITE;
                        base_d   = ({2'b00, grp_q} << 1) + {2'b00, grp_q};
                        pendWr_d = 1'b0;
                    end else begin
                        op_d     = OP_READ;
                        base_d   = 4'd0;
                        pendRd_d = 1'b0;
                    end
                end
            end
            S_XFER: begin
                if (fc_q == FCW'(FRAME_LEN - 1)) begin
                    fc_d = '0;
                    if (frm_q == ((op_q == OP_READ) ? 4'd8 : 4'd2)) begin
                        state_d = S_DONE;
                    end else begin
                        frm_d = frm_q + 4'd1;
                    end
                end else begin
                    fc_d = fc_q + FCW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                op_d    = OP_NONE;
            end
        endcase

        // New requests are applied after the grant so a pulse arriving in the
        // grant cycle stays pending for a later transaction.
        if (req_ini) pendIni_d = 1'b1;
        if (req_rd)  pendRd_d  = 1'b1;
        if (req_wr && (wr_grp != 2'b11)) begin
            pendWr_d = 1'b1;
            grp_d    = wr_grp;
        end

        inXfer      = (state_d == S_XFER);
        isRead      = (op_d == OP_READ);
        isWriteLike = (op_d == OP_WRITE) || (op_d == OP_INIT);
        idx_d       = base_d + frm_d;

        adN_d   = !(inXfer && inWin(fc_d, 1, 10));
        csN_d   = !(inXfer && (inWin(fc_d, 2, 8) || inWin(fc_d, 20, 26)));
        wrN_d   = !(inXfer && (inWin(fc_d, 2, 8) || (isWriteLike && inWin(fc_d, 20, 26))));
        rdN_d   = !(inXfer && isRead && inWin(fc_d, 20, 26));
        busOe_d = inXfer && (inWin(fc_d, 1, 10) || (isWriteLike && inWin(fc_d, 18, 28)));

        // bus_out is loaded at the start of each phase and held otherwise, so
        // wr_data is sampled exactly once per write frame.
        busOut_d = busOut_q;
        if (inXfer && (fc_d == FCW'(1))) begin
            busOut_d = (op_d == OP_INIT) ? initAddr(frm_d) : regAddr(idx_d);
        end else if (inXfer && isWriteLike && (fc_d == FCW'(18))) begin
            busOut_d = (op_d == OP_INIT) ? initData(frm_d) : wr_data;
        end

        wrIdx_d   = (inXfer && (op_d == OP_WRITE)) ? idx_d : 4'hF;
        rdValid_d = inXfer && isRead && (fc_d == FCW'(27));
        rdIdx_d   = rdValid_d ? idx_d : rdIdx_q;
        rdData_d  = rdValid_d ? bus_in : rdData_q;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // State and output registers; reset abandons any transaction in flight
    // together with all pending requests.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NONE;
            fc_q      <= '0;
            frm_q     <= 4'd0;
            base_q    <= 4'd0;
            grp_q     <= 2'b00;
            pendIni_q <= 1'b0;
            pendWr_q  <= 1'b0;
            pendRd_q  <= 1'b0;
            csN_q     <= 1'b1;
            rdN_q     <= 1'b1;
            wrN_q     <= 1'b1;
            adN_q     <= 1'b1;
            busOe_q   <= 1'b0;
            busOut_q  <= 8'h00;
            wrIdx_q   <= 4'hF;
            rdIdx_q   <= 4'd0;
            rdData_q  <= 8'h00;
            rdValid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            fc_q      <= fc_d;
            frm_q     <= frm_d;
            base_q    <= base_d;
            grp_q     <= grp_d;
            pendIni_q <= pendIni_d;
            pendWr_q  <= pendWr_d;
            pendRd_q  <= pendRd_d;
            csN_q     <= csN_d;
            rdN_q     <= rdN_d;
            wrN_q     <= wrN_d;
            adN_q     <= adN_d;
            busOe_q   <= busOe_d;
            busOut_q  <= busOut_d;
            wrIdx_q   <= wrIdx_d;
            rdIdx_q   <= rdIdx_d;
            rdData_q  <= rdData_d;
            rdValid_q <= rdValid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign cs_n     = csN_q;
    assign rd_n     = rdN_q;
    assign wr_n     = wrN_q;
    assign ad_n     = adN_q;
    assign bus_oe   = busOe_q;
    assign bus_out  = busOut_q;
    assign wr_idx   = wrIdx_q;
    assign rd_idx   = rdIdx_q;
    assign rd_data  = rdData_q;
    assign rd_valid = rdValid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cur_op   = op_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// tb_rtc_bus_scheduler
// Directed bench for rtc_bus_scheduler: reset state, a full read, a group
// write with a read queued behind it, last-wins group latching, simultaneous
// requests in priority order, and a reset in the middle of a read.
module tb_rtc_bus_scheduler;

    logic       reloj;
    logic       resetM;
    logic       req_ini;
    logic       req_wr;
    logic [1:0] wr_grp;
    logic       req_rd;
    logic [7:0] wr_data;
    logic [7:0] bus_in;
    logic       cs_n, rd_n, wr_n, ad_n, bus_oe;
    logic [7:0] bus_out;
    logic [3:0] wr_idx, rd_idx;
    logic [7:0] rd_data;
    logic       rd_valid, busy, done;
    logic [1:0] cur_op;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] addrLatch;
    int         injCyc[3];
    logic [4:0] injBits[3];

    rtc_bus_scheduler #(.FRAME_LEN(32)) dut (
        .reloj(reloj), .resetM(resetM), .req_ini(req_ini), .req_wr(req_wr),
        .wr_grp(wr_grp), .req_rd(req_rd), .wr_data(wr_data), .bus_in(bus_in),
        .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_n(ad_n), .bus_oe(bus_oe),
        .bus_out(bus_out), .wr_idx(wr_idx), .rd_idx(rd_idx), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .cur_op(cur_op)
    );

    // Free-running clock
    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    // Write data source: register idx n supplies byte n*0x11
    always_comb wr_data = {wr_idx, wr_idx};

    // RTC model: remembers the address of the current frame and answers addr+1
    always @(posedge reloj) begin
        if (resetM) addrLatch <= 8'h00;
        else if (bus_oe && !ad_n) addrLatch <= bus_out;
    end
    assign bus_in = addrLatch + 8'd1;

    // Watchdog so the run always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    function automatic logic [13:0] actVec();
        return {cur_op, busy, done, wr_idx, ad_n, cs_n, wr_n, rd_n, bus_oe, rd_valid};
    endfunction

    localparam logic [13:0] IDLE_VEC = 14'b00_0_0_1111_1_1_1_1_0_0;

    function automatic logic [7:0] addrOf(input int idx);
        case (idx)
            0: return 8'h24;  1: return 8'h25;  2: return 8'h26;
            3: return 8'h21;  4: return 8'h22;  5: return 8'h23;
            6: return 8'h41;  7: return 8'h42;  8: return 8'h43;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] initAddrOf(input int f);
        case (f)
            0: return 8'h02;  1: return 8'h02;  default: return 8'h10;
        endcase
    endfunction

    function automatic logic [7:0] initDataOf(input int f);
        case (f)
            0: return 8'h10;  1: return 8'h00;  default: return 8'hD2;
        endcase
    endfunction

    function automatic logic inW(input int k, input int lo, input int hi);
        return (k >= lo) && (k <= hi);
    endfunction

    task automatic clearInj();
        for (int s = 0; s < 3; s++) begin
            injCyc[s]  = -1;
            injBits[s] = 5'b0;
        end
    endtask

    // Issue request pulses from IDLE and advance to the first XFER cycle
    task automatic applyStimulus(input logic ini, input logic wr, input logic rd, input logic [1:0] grp);
        req_ini = ini;
        req_wr  = wr;
        req_rd  = rd;
        wr_grp  = grp;
        tick();
        req_ini = 1'b0;
        req_wr  = 1'b0;
        req_rd  = 1'b0;
        checkOutput("grant cycle busy", 32'(busy), 32'(1'b0));
        tick();
    endtask

    // Walks one transaction from its fc=0 cycle through DONE and the IDLE
    // cycle after it, checking every cycle. kind: 1 read, 2 write, 3 init.
    task automatic runTransaction(input int kind, input int nFrames, input int base, input int abortAt);
        int          j;
        logic        isW;
        logic [3:0]  wIdx;
        logic [13:0] expV;
        isW = (kind >= 2);
        for (int f = 0; f < nFrames; f++) begin
            for (int k = 0; k < 32; k++) begin
                j = f * 32 + k;
                if (j != 0) tick();
                req_ini = 1'b0;
                req_wr  = 1'b0;
                req_rd  = 1'b0;
                wIdx = (kind == 2) ? 4'(base + f) : 4'hF;
                expV = {2'(kind), 1'b1, 1'b0, wIdx,
                        !inW(k, 1, 10),
                        !(inW(k, 2, 8) || inW(k, 20, 26)),
                        !(inW(k, 2, 8) || (isW && inW(k, 20, 26))),
                        !((kind == 1) && inW(k, 20, 26)),
                        inW(k, 1, 10) || (isW && inW(k, 18, 28)),
                        (kind == 1) && (k == 27)};
                checkOutput($sformatf("op%0d f%0d k%0d strobes", kind, f, k), 32'(actVec()), 32'(expV));
                if (inW(k, 1, 10))
                    checkOutput($sformatf("op%0d f%0d k%0d addr", kind, f, k), 32'(bus_out),
                                32'((kind == 3) ? initAddrOf(f) : addrOf(base + f)));
                if (isW && inW(k, 18, 28))
                    checkOutput($sformatf("op%0d f%0d k%0d data", kind, f, k), 32'(bus_out),
                                32'((kind == 3) ? initDataOf(f) : {4'(base + f), 4'(base + f)}));
                if ((kind == 1) && (k == 27))
                    checkOutput($sformatf("rd f%0d capture", f), 32'({rd_idx, rd_data}),
                                32'({4'(f), addrOf(f) + 8'd1}));
                for (int s = 0; s < 3; s++) begin
                    if (injCyc[s] == j) begin
                        req_ini = injBits[s][4];
                        req_wr  = injBits[s][3];
                        req_rd  = injBits[s][2];
                        wr_grp  = injBits[s][1:0];
                    end
                end
                if (j == abortAt) begin
                    resetM = 1'b1;
                    req_rd = 1'b1;
                    return;
                end
            end
        end
        tick();
        req_ini = 1'b0;
        req_wr  = 1'b0;
        req_rd  = 1'b0;
        checkOutput($sformatf("op%0d done cycle", kind), 32'(actVec()),
                    32'({2'(kind), 1'b1, 1'b1, 4'hF, 6'b111100}));
        tick();
        checkOutput($sformatf("op%0d idle after done", kind), 32'(actVec()), 32'(IDLE_VEC));
    endtask

    // Watch the bus for a number of idle cycles, counting any activity
    task automatic idleWatch(input string tag, input int n);
        int activity;
        activity = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (!cs_n || bus_oe || busy || done || rd_valid) activity++;
        end
        checkOutput(tag, 32'(activity), 32'd0);
    endtask

    initial begin
        resetM  = 1'b1;
        req_ini = 1'b0;
        req_wr  = 1'b0;
        req_rd  = 1'b0;
        wr_grp  = 2'b00;
        clearInj();

        // Reset held three cycles, outputs at reset values
        tick(); tick(); tick();
        resetM = 1'b0;
        checkOutput("reset vector", 32'(actVec()), 32'(IDLE_VEC));
        checkOutput("reset bus_out", 32'(bus_out), 32'h00);
        checkOutput("reset rd_idx/rd_data", 32'({rd_idx, rd_data}), 32'h000);
        idleWatch("idle quiet after reset", 50);

        // Full read of all nine registers
        $display("[TB] read all registers");
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00);
        runTransaction(1, 9, 0, -1);

        // Write hora group with a read requested at fc=5 of the write
        $display("[TB] write hora with queued read");
        injCyc[0] = 5; injBits[0] = 5'b00100;
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b01);
        runTransaction(2, 3, 3, -1);
        clearInj();
        // Read starts two cycles after the write's done; two writes and a
        // dropped group-11 write are queued during it
        injCyc[0] = 10; injBits[0] = 5'b01010;
        injCyc[1] = 50; injBits[1] = 5'b01000;
        injCyc[2] = 60; injBits[2] = 5'b01011;
        tick();
        runTransaction(1, 9, 0, -1);
        clearInj();
        tick();
        runTransaction(2, 3, 0, -1);
        idleWatch("queued write ran once", 40);

        // Simultaneous requests: init, then write fecha, then read
        $display("[TB] simultaneous requests");
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b00);
        runTransaction(3, 3, 0, -1);
        tick();
        runTransaction(2, 3, 0, -1);
        tick();
        // Read aborted by reset at fc=22 of frame 4, with a write pending
        injCyc[0] = 10; injBits[0] = 5'b01001;
        runTransaction(1, 9, 0, 4 * 32 + 22);
        clearInj();
        tick();
        resetM = 1'b0;
        req_rd = 1'b0;
        checkOutput("mid-read reset vector", 32'(actVec()), 32'(IDLE_VEC));
        checkOutput("mid-read reset bus_out", 32'(bus_out), 32'h00);
        checkOutput("mid-read reset rd_idx/rd_data", 32'({rd_idx, rd_data}), 32'h000);
        idleWatch("pending cleared by reset", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
